// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares one FIFO write port
// (shift_in/si) between NREQ producers.
//
// A winner is picked in IDLE by scanning from a rotating pointer. It then
// owns the port for up to MAX_BURST words. Backpressure from the FIFO
// (full) holds the grant without counting toward the burst.
//
// Optional feature, selected with the macro FIFO_WR_ARB_STALL_CNT_EN:
// adds a 16-bit saturating stall_cnt output. It counts the cycles in which
// the owner has a word ready but the FIFO is full.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  data,
  input  logic                   full,
  output logic [NREQ-1:0]        grant,
  output logic                   shift_in,
  output logic [WIDTH-1:0]       si,
  output logic                   busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [0:0]      IDLE     = 1'b0;
  localparam logic [0:0]      BURST    = 1'b1;
  localparam logic [3:0]      LAST_CNT = 4'(MAX_BURST - 1);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

  logic [0:0]      state_reg, state_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [PW-1:0]   owner_reg, owner_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic [NREQ-1:0] grant_reg, grant_next;

  logic [WIDTH-1:0] data_arr [NREQ];
  logic [PW:0]      cand_sum [NREQ];
  logic [PW-1:0]    cand_idx [NREQ];
  logic [NREQ-1:0]  cand_req;

  logic             sel_found;
  logic [PW-1:0]    sel_idx;
  logic             in_burst;
  logic             owner_req;
  logic             leave;

  // Unpack the flat data bus and build the rotated scan order.
  // Candidate gi is requester (ptr + gi) mod NREQ.
  // It is computed one bit wider so the wrap is a single subtraction.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign data_arr[gi] = data[gi*WIDTH +: WIDTH];
      assign cand_sum[gi] = {1'b0, ptr_reg} + (PW+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (PW+1)'(NREQ))
                            ? PW'(cand_sum[gi] - (PW+1)'(NREQ))
                            : cand_sum[gi][PW-1:0];
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Priority pick of the first requesting candidate.
  // The loop runs downward so the lowest scan position wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx[k];
      end
    end
  end

  assign in_burst  = (state_reg == BURST);
  assign owner_req = req[owner_reg];

  // FIFO write port. A word in flight during reset is suppressed so that
  // a reset never leaks a half-granted write into the FIFO.
  assign shift_in = in_burst & owner_req & ~full & ~res;
  assign si       = in_burst ? data_arr[owner_reg] : '0;
  assign busy     = in_burst;
  assign grant    = grant_reg;

  // Next-state logic: arbitration in IDLE, and burst bookkeeping in BURST.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    leave      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next = BURST;
          owner_next = sel_idx;
          grant_next = NREQ'(1) << sel_idx;
          cnt_next   = '0;
        end
      end
      BURST: begin
        if (!owner_req) begin
          // Owner ran dry: end the burst without a transfer.
          leave = 1'b1;
        end else if (!full) begin
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg == LAST_CNT) begin
            leave = 1'b1;
          end
        end
        // full with a pending word: hold everything, no timeout.
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
    if (leave) begin
      state_next = IDLE;
      grant_next = '0;
      ptr_next   = (owner_reg == LAST_IDX) ? '0 : owner_reg + PW'(1);
    end
  end

  // State registers; reset wins over any burst in progress.
  always_ff @(posedge clk) begin
    if (res) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
      grant_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  // Saturating count of cycles where the owner is blocked by a full FIFO.
  always_ff @(posedge clk) begin
    if (res) begin
      stall_cnt_reg <= '0;
    end else if (in_burst && owner_req && full && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter.
//
// The driver issues random requests, data, full and reset. It steps a
// transaction-level model that uses integers for the owner, the burst count
// and the start pointer, and it queues the expected status and writes. A
// monitor process on the falling edge pops the queues and compares them
// with the DUT outputs. A second instance (NREQ=2, MAX_BURST=1) checks
// single-word alternation.
module tb_fifo_wr_arbiter;
  localparam int WIDTH     = 4;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  res;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic                  full;
  logic [NREQ-1:0]       grant;
  logic                  shift_in;
  logic [WIDTH-1:0]      si;
  logic                  busy;
  logic [15:0]           stall_cnt;

  logic                  res2;
  logic [1:0]            req2;
  logic [2*WIDTH-1:0]    data2;
  logic                  full2;
  logic [1:0]            grant2;
  logic                  shift_in2;
  logic [WIDTH-1:0]      si2;
  logic                  busy2;
  logic [15:0]           stall_cnt2;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .res(res), .req(req), .data(data), .full(full),
    .grant(grant), .shift_in(shift_in), .si(si), .busy(busy), .stall_cnt(stall_cnt));
  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(2), .MAX_BURST(1)) dut2 (
    .clk(clk), .res(res2), .req(req2), .data(data2), .full(full2),
    .grant(grant2), .shift_in(shift_in2), .si(si2), .busy(busy2), .stall_cnt(stall_cnt2));
`else
  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .res(res), .req(req), .data(data), .full(full),
    .grant(grant), .shift_in(shift_in), .si(si), .busy(busy));
  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(2), .MAX_BURST(1)) dut2 (
    .clk(clk), .res(res2), .req(req2), .data(data2), .full(full2),
    .grant(grant2), .shift_in(shift_in2), .si(si2), .busy(busy2));
  assign stall_cnt  = 16'd0;
  assign stall_cnt2 = 16'd0;
`endif

  typedef struct {
    logic [NREQ-1:0] grant;
    logic            busy;
    logic            shift_in;
    int              stall;
    int              cyc;
  } status_t;

  typedef struct {
    logic [WIDTH-1:0] word;
    int               src;
  } wr_t;

  status_t st_q[$];
  wr_t     wr_q[$];

  int checks   = 0;
  int failures = 0;
  int shifts   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Reference model state (spec-level): owner -1 means idle.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;
  int m_stall = 0;
  logic [NREQ-1:0] consumed = '0;

  // Monitor: compare status every cycle, and pop a write whenever DUT strobes.
  initial begin
    status_t s;
    wr_t     w;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (st_q.size() == 0) begin
          failures++;
          $display("FAIL status_underflow got=empty required=entry");
        end else begin
          s = st_q.pop_front();
          if (grant !== s.grant || busy !== s.busy || shift_in !== s.shift_in) begin
            failures++;
            $display("FAIL status cyc=%0d got grant=%b busy=%b shift_in=%b required grant=%b busy=%b shift_in=%b",
                     s.cyc, grant, busy, shift_in, s.grant, s.busy, s.shift_in);
          end
`ifdef FIFO_WR_ARB_STALL_CNT_EN
          checks++;
          if (int'(stall_cnt) != s.stall) begin
            failures++;
            $display("FAIL stall_cnt cyc=%0d got=%0d required=%0d", s.cyc, stall_cnt, s.stall);
          end
`endif
        end
        if (shift_in === 1'b1) begin
          shifts++;
          checks++;
          if (wr_q.size() == 0) begin
            failures++;
            $display("FAIL write_unexpected got si=%h required=no_write", si);
          end else begin
            w = wr_q.pop_front();
            if (si !== w.word || grant[w.src] !== 1'b1) begin
              failures++;
              $display("FAIL write got si=%h grant=%b required si=%h from req%0d",
                       si, grant, w.word, w.src);
            end
          end
        end
      end
    end
  end

  // One clock of stimulus plus the reference model step.
  task automatic drive_cycle(input int p_req, input int p_full, input int p_res,
                             input bit force_all, input bit force_res);
    logic [NREQ-1:0]       r;
    logic [NREQ*WIDTH-1:0] d;
    logic                  f;
    logic                  rs;
    logic                  oreq;
    bit                    xf;
    bit                    lv;
    status_t               s;
    wr_t                   w;
    @(posedge clk);
    #1;
    r = req;
    d = data;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && !consumed[i]) begin
        // Pending word must stay put; the producer may still withdraw.
        if (!force_all && $urandom_range(99) < 5) r[i] = 1'b0;
      end else begin
        r[i] = force_all || ($urandom_range(99) < p_req);
        d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
    end
    f  = ($urandom_range(99) < p_full);
    rs = force_res || ($urandom_range(99) < p_res);
    req = r; data = d; full = f; res = rs;

    s.grant    = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
    s.busy     = (m_owner >= 0);
    oreq       = (m_owner >= 0) ? r[m_owner] : 1'b0;
    xf         = s.busy && oreq && !f && !rs;
    s.shift_in = xf;
    s.stall    = m_stall;
    s.cyc      = cyc;
    st_q.push_back(s);
    if (xf) begin
      w.word = d[m_owner*WIDTH +: WIDTH];
      w.src  = m_owner;
      wr_q.push_back(w);
    end
    consumed = s.grant & r & {NREQ{~f}};
    mon_en = 1'b1;

    if (rs) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_stall = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % NREQ]) begin
          m_owner = (m_ptr + k) % NREQ;
          m_cnt   = 0;
        end
      end
    end else begin
      lv = 1'b0;
      if (!oreq) lv = 1'b1;
      else if (f) begin
        if (m_stall < 65535) m_stall++;
      end else begin
        m_cnt++;
        if (m_cnt == MAX_BURST) lv = 1'b1;
      end
      if (lv) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
    cyc++;
  endtask

  initial begin
    int snap;
    res = 1'b1; req = '0; data = '0; full = 1'b0;
    res2 = 1'b1; req2 = '0; data2 = '0; full2 = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then continuous requests: 16 writes in 20 cycles.
    repeat (2) drive_cycle(0, 0, 0, 1'b0, 1'b1);
    snap = shifts;
    repeat (20) drive_cycle(100, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (shifts - snap != 16) begin
      failures++;
      $display("FAIL throughput got=%0d writes required=16 in 20 cycles", shifts - snap);
    end

    // Random traffic with backpressure, withdrawals and occasional reset.
    repeat (2000) drive_cycle(40, 20, 1, 1'b0, 1'b0);
    repeat (500)  drive_cycle(70, 60, 0, 1'b0, 1'b0);
    repeat (500)  drive_cycle(10, 5, 1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    mon_en = 1'b0;

    // NREQ=2, MAX_BURST=1 with both requesting: alternating single words.
    data2 = {4'h5, 4'hA};
    for (int c = 0; c < 8; c++) begin
      logic [1:0]       eg;
      logic             es;
      logic [WIDTH-1:0] ed;
      @(posedge clk);
      #1;
      res2 = 1'b0; req2 = 2'b11; full2 = 1'b0;
      @(negedge clk);
      eg = (c % 2 == 0) ? 2'b00 : ((c % 4 == 1) ? 2'b01 : 2'b10);
      es = (c % 2 == 1);
      ed = (c % 2 == 0) ? 4'h0 : ((c % 4 == 1) ? 4'hA : 4'h5);
      checks++;
      if (grant2 !== eg || shift_in2 !== es || si2 !== ed || busy2 !== es) begin
        failures++;
        $display("FAIL alt2 c=%0d got grant=%b shift_in=%b si=%h required grant=%b shift_in=%b si=%h",
                 c, grant2, shift_in2, si2, eg, es, ed);
      end
    end

    checks++;
    if (st_q.size() != 0 || wr_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained got status=%0d writes=%0d required 0 0", st_q.size(), wr_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
